// File: rtl/rom_stream_reader.sv
// rom_stream_reader
// Read-side sequencer for a 16x16 synchronous single-address ROM. A start
// command walks a contiguous, wrapping address range. The block drives the
// ROM en/addr pins and absorbs the ROM's one-cycle read latency. Words are
// returned on a valid/ready stream through a 2-entry FIFO, so a stalled
// consumer never loses data.
//
// Read issue is qualified by the consumer's handshake in the same cycle.
// This keeps buffer occupancy plus the in-flight read at two words or fewer,
// and still sustains one word per cycle while out_ready_i stays high.
// rom_addr_o, the FSM and the FIFO are all flops.

module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // Sequencer state
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;           // next address to read
  logic [ADDR_W:0]   issue_left_q, issue_left_d;
  logic [ADDR_W:0]   deliver_left_q, deliver_left_d;
  logic              done_q, done_d;

  // A read whose data is on rom_data_i this cycle and is captured at the
  // coming edge.
  logic              cap_q, cap_d;

  // Two-entry output FIFO
  logic [DATA_W-1:0] mem_q [2];
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  logic              out_valid;
  logic              pop;
  logic [2:0]        fill_after_pop;
  logic              room;
  logic              issue;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready_i;

  // Words already committed to the buffer once this cycle's capture and pop
  // settle. A new read is allowed only if that leaves a free slot for it.
  assign fill_after_pop = {1'b0, occ_q} + {2'b00, cap_q} - {2'b00, pop};
  assign room           = (fill_after_pop < 3'd2);
  assign issue          = (state_q == ST_FETCH) && (issue_left_q != CNT_ZERO) && room;

  // Next-state logic for the burst sequencer
  // NOTE: every always_comb output is assigned a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    issue_left_d   = issue_left_q;
    deliver_left_d = deliver_left_q;
    done_d         = 1'b0;

    if (pop) begin
      deliver_left_d = deliver_left_q - CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (count_i != CNT_ZERO) begin
            state_d        = ST_FETCH;
            addr_d         = base_addr_i;
            issue_left_d   = count_i;
            deliver_left_d = count_i;
          end else begin
            // An empty burst makes no ROM access and only acknowledges.
            done_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (issue) begin
          addr_d       = addr_q + ADDR_ONE;   // wraps modulo 2^ADDR_W
          issue_left_d = issue_left_q - CNT_ONE;
          if (issue_left_q == CNT_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (pop && (deliver_left_q == CNT_ONE)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    cap_d    = issue;
    occ_d    = occ_q + {1'b0, cap_q} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ cap_q;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  // Sequencer registers; reset discards any read that is in flight
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      done_q         <= 1'b0;
      cap_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      done_q         <= done_d;
      cap_q          <= cap_d;
    end
  end

  // FIFO storage and pointers; flushed by reset
  // NOTE: the two data entries are reset as well. The array is tiny, and
  // reset then gives out_data a defined value before anything is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (cap_q) begin
        mem_q[wr_ptr_q] <= rom_data_i;
      end
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign rom_en_o    = issue;
  assign rom_addr_o  = addr_q;
  assign out_valid_o = out_valid;
  assign out_data_o  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last_o  = out_valid && (deliver_left_q == CNT_ONE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader. Each burst pushes its expected
// addresses and words. A negedge monitor pops and compares them as the DUT
// issues reads and hands words out.

module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  count;
  logic        busy, done, rom_en;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        out_valid, out_last, out_ready;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .count_i     (count),
    .busy_o      (busy),
    .done_o      (done),
    .rom_en_o    (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

  // ROM contents
  function automatic logic [15:0] rom_word(input logic [3:0] a);
    case (a)
      4'h0: rom_word = 16'h3C01;  4'h1: rom_word = 16'h5A12;
      4'h2: rom_word = 16'h7E23;  4'h3: rom_word = 16'h9134;
      4'h4: rom_word = 16'hB245;  4'h5: rom_word = 16'hD356;
      4'h6: rom_word = 16'hF467;  4'h7: rom_word = 16'h1578;
      4'h8: rom_word = 16'h2689;  4'h9: rom_word = 16'h479A;
      4'hA: rom_word = 16'h68AB;  4'hB: rom_word = 16'h89BC;
      4'hC: rom_word = 16'hAACD;  4'hD: rom_word = 16'hCBDE;
      4'hE: rom_word = 16'hECEF;  default: rom_word = 16'h0DF0;
    endcase
  endfunction

  // Synchronous ROM: garbage on cycles without a read, so late or early
  // capture is visible
  always @(posedge clk) rom_data <= rom_en ? rom_word(rom_addr) : 16'hDEAD;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [3:0] exp_addr_q[$];

  // Monitor state
  int          outstanding = 0;
  int          hs_count    = 0;
  logic        prev_stall  = 1'b0;
  logic [15:0] prev_data   = '0;
  logic        prev_last   = 1'b0;
  logic        mon_pop;
  logic [3:0]  mon_addr;
  word_t       mon_word;

  always @(negedge clk) begin
    if (!rst) begin
      mon_pop = out_valid && out_ready;
      if (rom_en) begin
        if (exp_addr_q.size() == 0) begin
          fail_now("spurious_rom_en");
        end else begin
          mon_addr = exp_addr_q.pop_front();
          check("rom_addr", rom_addr, mon_addr);
        end
        check("occupancy_bound", ((outstanding + 1 - int'(mon_pop)) <= 2), 1);
      end
      if (out_valid && prev_stall) begin
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (mon_pop) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          mon_word = exp_q.pop_front();
          check("out_data", out_data, mon_word.data);
          check("out_last", out_last, mon_word.last);
        end
        hs_count++;
      end
      outstanding = outstanding + int'(rom_en) - int'(mon_pop);
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_last   = out_last;
    end
  end

  // Consumer ready: high unless a backpressure pattern is playing
  logic       bp_en  = 1'b0;
  int         bp_idx = 0;
  logic [7:0] bp_pat = 8'b1101_0001;   // bit i = ready in pattern cycle i: 1,0,0,0,1,0,1,1

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) begin
        out_ready = (bp_idx < 8) ? bp_pat[bp_idx] : 1'b1;
        bp_idx++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic push_expect(input logic [3:0] base, input logic [4:0] cnt);
    logic [3:0] a;
    word_t      w;
    for (int i = 0; i < int'(cnt); i++) begin
      a      = base + i[3:0];
      w.data = rom_word(a);
      w.last = (i == int'(cnt) - 1);
      exp_addr_q.push_back(a);
      exp_q.push_back(w);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_rom_en"},    rom_en,    0);
    check({tag, "_rom_addr"},  rom_addr,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
  endtask

  // One burst: timed checks cycle-exact latency, bp plays the ready pattern,
  // mid_start fires a conflicting start while busy.
  task automatic run_burst(input logic [3:0] base, input logic [4:0] cnt,
                           input bit timed, input bit bp, input bit mid_start);
    int c;
    int lim;
    push_expect(base, cnt);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    c         = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ~base;      // mid-burst input changes must not matter
    count     = 5'd3;
    check("busy_after_start", busy, (cnt != 5'd0));
    lim = 0;
    while (!done && lim < 300) begin
      if (timed && cnt != 5'd0 && cyc == c + 2) check("valid_before_latency", out_valid, 0);
      if (timed && cnt != 5'd0 && cyc == c + 3) check("first_valid_cycle", out_valid, 1);
      if (bp && cyc == c + 3) bp_en = 1'b1;
      if (mid_start && cyc == c + 3) begin
        start     = 1'b1;
        base_addr = 4'h9;
        count     = 5'd3;
      end
      if (mid_start && cyc == c + 4) start = 1'b0;
      @(posedge clk); #1;
      lim++;
    end
    if (!done) begin
      fail_now("done_timeout");
    end else begin
      if (timed) check("done_cycle", cyc - c, (cnt == 5'd0) ? 1 : int'(cnt) + 3);
      check("busy_at_done", busy, 0);
      check("words_left", exp_q.size(), 0);
      check("addrs_left", exp_addr_q.size(), 0);
    end
    bp_en  = 1'b0;
    bp_idx = 0;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int lim;
    int h0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run_burst(4'd0,  5'd8,  1, 0, 0);   // basic
    run_burst(4'd14, 5'd4,  1, 0, 0);   // wrap 14,15,0,1
    run_burst(4'd3,  5'd6,  0, 1, 0);   // backpressure
    run_burst(4'd0,  5'd0,  1, 0, 0);   // empty burst
    run_burst(4'd5,  5'd16, 1, 0, 0);   // full depth 5..15,0..4
    run_burst(4'd7,  5'd6,  1, 0, 1);   // start while busy

    // Reset in the middle of a burst
    push_expect(4'd0, 5'd8);
    h0 = hs_count;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 4'd0;
    count     = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    lim   = 0;
    while (hs_count < h0 + 3 && lim < 100) begin
      @(posedge clk); #1;
      lim++;
    end
    if (hs_count < h0 + 3) fail_now("handshake_timeout");
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    prev_stall  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    run_burst(4'd2, 5'd2, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
